tx_controller: RTL and testbench

Transmit-side controller for the UART command system. It captures register-file read data or an ALU result and splits it into a byte frame. It then feeds that frame one byte at a time to the UART TX serializer, using a valid/busy handshake. It is the return path for the receive controller: read and ALU replies go out through this block.

---
 rtl/tx_controller.sv | 161 ++++++++++++++++
 tb/tb_tx_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_controller.sv
// tx_controller: frames register-file read data (1 byte) or an ALU result (2 bytes, low first)
// onto the UART TX valid/busy handshake. Define TXCONT_CHECKSUM_EN to append an XOR checksum byte.
module tx_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    TXCont_CLK,
    input  logic                    TXCont_RST,
    input  logic [DATA_WIDTH-1:0]   TXCont_RF_RdData,
    input  logic                    TXCont_RF_RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] TXCont_ALU_Out,
    input  logic                    TXCont_ALU_Valid,
    input  logic                    TXCont_Busy,
    output logic [DATA_WIDTH-1:0]   TXCont_Pdata,
    output logic                    TXCont_Data_Valid,
    output logic                    TXCont_Frame_Busy,
    output logic                    TXCont_Overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                  state_r;
    logic [1:0]              index_r;
    logic [1:0]              last_idx_r;
    logic [DATA_WIDTH-1:0]   slot0_r;
    logic [DATA_WIDTH-1:0]   slot1_r;
    logic [DATA_WIDTH-1:0]   pdata_r;
    logic                    overrun_r;
    logic [DATA_WIDTH-1:0]   next_byte_s;
    logic [1:0]              next_index_s;
    logic                    strobe_any_s;
    logic                    strobe_both_s;

`ifdef TXCONT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   slot2_r;

    function automatic logic [DATA_WIDTH-1:0] xor_checksum(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a ^ b;
    endfunction
`endif

    assign strobe_any_s  = TXCont_RF_RdData_Valid | TXCont_ALU_Valid;
    assign strobe_both_s = TXCont_RF_RdData_Valid & TXCont_ALU_Valid;
    assign next_index_s  = index_r + 2'd1;

    // Selects the buffered byte that follows the one currently on the wire
    always_comb begin
        next_byte_s = {DATA_WIDTH{1'b0}};
        case (next_index_s)
            2'd0:    next_byte_s = slot0_r;
            2'd1:    next_byte_s = slot1_r;
`ifdef TXCONT_CHECKSUM_EN
            2'd2:    next_byte_s = slot2_r;
`endif
            default: next_byte_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Frame FSM: accepts one strobe in IDLE, then walks the buffer one handshake per byte
    always_ff @(posedge TXCont_CLK or negedge TXCont_RST) begin
        if (!TXCont_RST) begin
            state_r    <= IDLE;
            index_r    <= 2'd0;
            last_idx_r <= 2'd0;
            slot0_r    <= {DATA_WIDTH{1'b0}};
            slot1_r    <= {DATA_WIDTH{1'b0}};
`ifdef TXCONT_CHECKSUM_EN
            slot2_r    <= {DATA_WIDTH{1'b0}};
`endif
            pdata_r    <= {DATA_WIDTH{1'b0}};
            overrun_r  <= 1'b0;
        end else begin
            // In IDLE only the losing ALU strobe of a simultaneous pair is dropped
            if (state_r == IDLE) begin
                overrun_r <= strobe_both_s;
            end else begin
                overrun_r <= strobe_any_s;
            end

            case (state_r)
                IDLE: begin
                    index_r <= 2'd0;
                    if (TXCont_RF_RdData_Valid) begin
                        slot0_r <= TXCont_RF_RdData;
                        pdata_r <= TXCont_RF_RdData;
`ifdef TXCONT_CHECKSUM_EN
                        slot1_r    <= xor_checksum(TXCont_RF_RdData, {DATA_WIDTH{1'b0}});
                        last_idx_r <= 2'd1;
`else
                        last_idx_r <= 2'd0;
`endif
                        state_r <= SEND;
                    end else if (TXCont_ALU_Valid) begin
                        slot0_r <= TXCont_ALU_Out[DATA_WIDTH-1:0];
                        slot1_r <= TXCont_ALU_Out[2*DATA_WIDTH-1:DATA_WIDTH];
                        pdata_r <= TXCont_ALU_Out[DATA_WIDTH-1:0];
`ifdef TXCONT_CHECKSUM_EN
                        slot2_r    <= xor_checksum(TXCont_ALU_Out[DATA_WIDTH-1:0],
                                                   TXCont_ALU_Out[2*DATA_WIDTH-1:DATA_WIDTH]);
                        last_idx_r <= 2'd2;
`else
                        last_idx_r <= 2'd1;
`endif
                        state_r <= SEND;
                    end else begin
                        pdata_r <= {DATA_WIDTH{1'b0}};
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (!TXCont_Busy) begin
                        state_r <= WAIT_HI;
                    end else begin
                        state_r <= SEND;
                    end
                end
                WAIT_HI: begin
                    if (TXCont_Busy) begin
                        state_r <= WAIT_LO;
                    end else begin
                        state_r <= WAIT_HI;
                    end
                end
                WAIT_LO: begin
                    if (!TXCont_Busy) begin
                        if (index_r == last_idx_r) begin
                            index_r <= 2'd0;
                            pdata_r <= {DATA_WIDTH{1'b0}};
                            state_r <= IDLE;
                        end else begin
                            index_r <= next_index_s;
                            pdata_r <= next_byte_s;
                            state_r <= SEND;
                        end
                    end else begin
                        state_r <= WAIT_LO;
                    end
                end
                default: begin
                    index_r <= 2'd0;
                    pdata_r <= {DATA_WIDTH{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Data_Valid is gated by the live Busy so a request never overlaps serialization
    assign TXCont_Data_Valid = (state_r == SEND) & ~TXCont_Busy;
    assign TXCont_Pdata      = pdata_r;
    assign TXCont_Frame_Busy = (state_r != IDLE);
    assign TXCont_Overrun    = overrun_r;

endmodule

// File: tb/tb_tx_controller.sv
// tb_tx_controller: directed + randomized bench for tx_controller against a byte-queue
// transaction model and a simple UART TX busy model.
module tb_tx_controller;

    localparam int DW = 8;

    logic            TXCont_CLK = 1'b0;
    logic            TXCont_RST;
    logic [DW-1:0]   TXCont_RF_RdData;
    logic            TXCont_RF_RdData_Valid;
    logic [2*DW-1:0] TXCont_ALU_Out;
    logic            TXCont_ALU_Valid;
    logic            TXCont_Busy;
    logic [DW-1:0]   TXCont_Pdata;
    logic            TXCont_Data_Valid;
    logic            TXCont_Frame_Busy;
    logic            TXCont_Overrun;

    tx_controller #(.DATA_WIDTH(DW)) dut (
        .TXCont_CLK             (TXCont_CLK),
        .TXCont_RST             (TXCont_RST),
        .TXCont_RF_RdData       (TXCont_RF_RdData),
        .TXCont_RF_RdData_Valid (TXCont_RF_RdData_Valid),
        .TXCont_ALU_Out         (TXCont_ALU_Out),
        .TXCont_ALU_Valid       (TXCont_ALU_Valid),
        .TXCont_Busy            (TXCont_Busy),
        .TXCont_Pdata           (TXCont_Pdata),
        .TXCont_Data_Valid      (TXCont_Data_Valid),
        .TXCont_Frame_Busy      (TXCont_Frame_Busy),
        .TXCont_Overrun         (TXCont_Overrun)
    );

    always #5 TXCont_CLK = ~TXCont_CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: bytes still to be requested, plus the outstanding-request handshake
    logic [DW-1:0] mdl_q[$];
    bit            mdl_act;
    bit            mdl_out;
    bit            mdl_seen;
    logic [DW-1:0] mdl_last;
    bit            mdl_ov;

    // UART TX model
    int busy_cnt  = 0;
    int stall_cnt = 0;
    bit rand_busy = 1'b0;

    task automatic model_reset();
        mdl_q.delete();
        mdl_act  = 1'b0;
        mdl_out  = 1'b0;
        mdl_seen = 1'b0;
        mdl_last = '0;
        mdl_ov   = 1'b0;
    endtask

    task automatic model_advance(input bit rf_v, input logic [DW-1:0] rf_d,
                                 input bit alu_v, input logic [2*DW-1:0] alu_d, input bit busy);
        if (!TXCont_RST) begin
            model_reset();
        end else if (!mdl_act) begin
            mdl_ov = rf_v && alu_v;
            if (rf_v) begin
                mdl_q.push_back(rf_d);
`ifdef TXCONT_CHECKSUM_EN
                mdl_q.push_back(rf_d);
`endif
                mdl_act = 1'b1;
            end else if (alu_v) begin
                mdl_q.push_back(alu_d[7:0]);
                mdl_q.push_back(alu_d[15:8]);
`ifdef TXCONT_CHECKSUM_EN
                mdl_q.push_back(alu_d[7:0] ^ alu_d[15:8]);
`endif
                mdl_act = 1'b1;
            end
        end else begin
            mdl_ov = rf_v || alu_v;
            if (!mdl_out) begin
                if (!busy) begin
                    mdl_last = mdl_q.pop_front();
                    mdl_out  = 1'b1;
                    mdl_seen = 1'b0;
                end
            end else if (!mdl_seen) begin
                if (busy) mdl_seen = 1'b1;
            end else if (!busy) begin
                mdl_out = 1'b0;
                if (mdl_q.size() == 0) mdl_act = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs after the edge, check outputs at the falling edge
    task automatic cycle(input bit rf_v, input logic [DW-1:0] rf_d,
                         input bit alu_v, input logic [2*DW-1:0] alu_d);
        bit            exp_dv;
        logic [DW-1:0] exp_pd;
        @(posedge TXCont_CLK);
        #1;
        TXCont_Busy = (busy_cnt > 0) || (stall_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (stall_cnt > 0) stall_cnt--;
        TXCont_RF_RdData_Valid = rf_v;
        TXCont_RF_RdData       = rf_d;
        TXCont_ALU_Valid       = alu_v;
        TXCont_ALU_Out         = alu_d;
        @(negedge TXCont_CLK);
        exp_dv = mdl_act && !mdl_out && !TXCont_Busy;
        if (!mdl_act)     exp_pd = '0;
        else if (mdl_out) exp_pd = mdl_last;
        else              exp_pd = (mdl_q.size() > 0) ? mdl_q[0] : '0;
        check_eq("data_valid", TXCont_Data_Valid, exp_dv);
        check_eq("pdata", TXCont_Pdata, exp_pd);
        check_eq("frame_busy", TXCont_Frame_Busy, mdl_act);
        check_eq("overrun", TXCont_Overrun, mdl_ov);
        if (TXCont_Data_Valid) busy_cnt = rand_busy ? $urandom_range(1, 12) : 10;
        model_advance(rf_v, rf_d, alu_v, alu_d, TXCont_Busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (mdl_act && n < 400) begin
            cycle(1'b0, '0, 1'b0, '0);
            n++;
        end
        cycle(1'b0, '0, 1'b0, '0);
        check_eq(tag, TXCont_Frame_Busy, 1'b0);
    endtask

    initial begin
        TXCont_RST             = 1'b0;
        TXCont_RF_RdData       = '0;
        TXCont_RF_RdData_Valid = 1'b0;
        TXCont_ALU_Out         = '0;
        TXCont_ALU_Valid       = 1'b0;
        TXCont_Busy            = 1'b0;
        model_reset();

        idle(2);
        TXCont_RST = 1'b1;
        idle(2);

        // Single RF byte
        cycle(1'b1, 8'h5A, 1'b0, '0);
        wait_idle("rf_done");

        // ALU result, low byte first
        cycle(1'b0, '0, 1'b1, 16'h1234);
        wait_idle("alu_done");

        // Simultaneous strobes: RF wins, ALU dropped
        cycle(1'b1, 8'hA1, 1'b1, 16'hBEEF);
        wait_idle("both_done");

        // ALU strobe during an active frame is dropped
        cycle(1'b1, 8'h77, 1'b0, '0);
        idle(3);
        cycle(1'b0, '0, 1'b1, 16'h9999);
        wait_idle("drop_done");

        // Busy held high at the start of SEND
        cycle(1'b1, 8'hC3, 1'b0, '0);
        stall_cnt = 5;
        wait_idle("stall_done");

        // Reset while waiting for Busy to fall on byte 0 of an ALU frame
        cycle(1'b0, '0, 1'b1, 16'h1234);
        begin
            int n = 0;
            while (!(mdl_out && mdl_seen && mdl_q.size() > 0) && n < 100) begin
                cycle(1'b0, '0, 1'b0, '0);
                n++;
            end
            check_eq("reach_wait_lo", (n < 100) ? 1'b1 : 1'b0, 1'b1);
        end
        @(posedge TXCont_CLK);
        #1;
        TXCont_RST = 1'b0;
        #1;
        check_eq("rst_pdata", TXCont_Pdata, 8'h00);
        check_eq("rst_dv", TXCont_Data_Valid, 1'b0);
        check_eq("rst_fb", TXCont_Frame_Busy, 1'b0);
        check_eq("rst_ov", TXCont_Overrun, 1'b0);
        busy_cnt  = 0;
        stall_cnt = 0;
        model_reset();
        idle(2);
        TXCont_RST = 1'b1;
        idle(1);
        cycle(1'b1, 8'h3C, 1'b0, '0);
        wait_idle("post_rst_done");

        // Randomized traffic
        rand_busy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (stall_cnt == 0 && $urandom_range(0, 30) == 0) stall_cnt = $urandom_range(1, 4);
            cycle(($urandom_range(0, 9) == 0), 8'($urandom),
                  ($urandom_range(0, 9) == 0), 16'($urandom));
        end
        wait_idle("rand_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
